// File: rtl/handshakes_delay_ready.sv
// Two-entry skid buffer: registered valid/ready slice with OUT and SKID.
// Ports: clk, rst (sync, high), up_valid/up_data/up_ready, down_valid/down_data/down_ready.
module handshakes_delay_ready #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  input  logic [WORD_WIDTH-1:0] up_data,
  output logic                  up_ready,
  output logic                  down_valid,
  output logic [WORD_WIDTH-1:0] down_data,
  input  logic                  down_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state;
  logic [WORD_WIDTH-1:0] skid;
  logic                  up_xfer;
  logic                  dn_xfer;

  assign up_xfer = up_valid & up_ready;
  assign dn_xfer = down_valid & down_ready;

  // up_ready is loaded with (next state != FULL) on every edge, so it
  // never sees down_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      down_data  <= '0;
      skid       <= '0;
      down_valid <= 1'b0;
      up_ready   <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          up_ready <= 1'b1;
          if (up_xfer) begin
            down_data  <= up_data;
            down_valid <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          unique case ({up_xfer, dn_xfer})
            2'b10: begin
              skid     <= up_data;
              up_ready <= 1'b0;
              state    <= FULL;
            end
            2'b01: begin
              down_valid <= 1'b0;
              state      <= EMPTY;
            end
            2'b11: begin
              down_data <= up_data;
            end
            default: begin
            end
          endcase
        end
        FULL: begin
          if (dn_xfer) begin
            down_data <= skid;
            up_ready  <= 1'b1;
            state     <= BUSY;
          end
        end
        default: begin
          down_valid <= 1'b0;
          up_ready   <= 1'b0;
          state      <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshakes_delay_ready.sv
// Random and directed stimulus against a queue model of the skid buffer.
// Reports FAIL lines per mismatch and a single summary line.
module tb_handshakes_delay_ready;

  logic       clk;
  logic       rst;
  logic       up_valid;
  logic [7:0] up_data;
  logic       up_ready;
  logic       down_valid;
  logic [7:0] down_data;
  logic       down_ready;

  int total;
  int bad;

  logic [7:0] q[$];
  logic       m_rdy;
  logic       m_zero;

  handshakes_delay_ready #(.WORD_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Buffer contents as a FIFO of at most two words; the block
  // accepts whenever fewer than two words are held, except
  // on the first edge out of reset.
  task automatic cyc(input logic r, input logic uv,
                     input logic [7:0] ud, input logic dr);
    logic acc;
    logic dq;
    rst        = r;
    up_valid   = uv;
    up_data    = ud;
    down_ready = dr;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rdy  = 1'b0;
      m_zero = 1'b1;
    end else begin
      acc = uv && m_rdy;
      dq  = (q.size() != 0) && dr;
      if (dq) void'(q.pop_front());
      if (acc) begin
        q.push_back(ud);
        m_zero = 1'b0;
      end
      m_rdy = q.size() < 2;
    end
    @(negedge clk);
    chk("up_ready", 32'(up_ready), 32'(m_rdy));
    chk("down_valid", 32'(down_valid), 32'(q.size() != 0));
    if (q.size() != 0)
      chk("down_data", 32'(down_data), 32'(q[0]));
    else if (m_zero)
      chk("data_zero", 32'(down_data), 32'd0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m_rdy  = 1'b0;
    m_zero = 1'b1;

    // reset with up_valid high
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);

    // single word, then skid fill and drain
    cyc(1'b0, 1'b1, 8'h5A, 1'b0);
    cyc(1'b0, 1'b1, 8'hC3, 1'b0);
    cyc(1'b0, 1'b1, 8'h77, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // streaming
    for (int i = 1; i <= 8; i++)
      cyc(1'b0, 1'b1, 8'(i), 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // toggling down_ready
    for (int i = 0; i < 200; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
          1'(i % 2));

    // fully random with occasional reset
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), 8'($urandom),
          1'($urandom_range(0, 1)));

    // mid-stream reset while FULL
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h11, 1'b0);
    cyc(1'b0, 1'b1, 8'h22, 1'b0);
    chk("full_ready", 32'(up_ready), 32'd0);
    cyc(1'b1, 1'b1, 8'h33, 1'b0);
    chk("skid_rst", 32'(dut.skid), 32'd0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h44, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/handshakes_delay_ready.md
HANDSHAKES_DELAY_READY -- requirements
Module: handshakes_delay_ready

Interface
REQ-001 Parameter: WORD_WIDTH, default 8, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 up_valid  input  1  upstream word valid.
REQ-005 up_data  input  WORD_WIDTH  upstream payload.
REQ-006 up_ready  output  1  block can accept a word; driven directly from a flip-flop.
REQ-007 down_valid  output  1  downstream word valid; driven directly from a flip-flop.
REQ-008 down_data  output  WORD_WIDTH  downstream payload; driven directly from the output data register.
REQ-009 down_ready  input  1  downstream accepts the word.

Function
REQ-010 The block SHALL be a two-entry skid buffer (ready-path register slice): output register OUT plus skid register SKID; no combinational path from any input to any output.
REQ-011 Transfer rules: upstream transfer when up_valid=1 and up_ready=1 at a rising edge; downstream transfer when down_valid=1 and down_ready=1 at a rising edge.
REQ-012 States: EMPTY (0 words), BUSY (OUT holds 1 word), FULL (OUT and SKID hold 1 word each).
REQ-013 Outputs per state: up_ready=1 in EMPTY and BUSY, 0 in FULL; down_valid=1 in BUSY and FULL, 0 in EMPTY.
REQ-014 EMPTY + upstream transfer -> OUT<=up_data, go to BUSY; otherwise stay in EMPTY.
REQ-015 BUSY + upstream only -> SKID<=up_data, go to FULL.
REQ-016 BUSY + downstream only -> go to EMPTY.
REQ-017 BUSY + both transfers in the same cycle -> OUT<=up_data, stay in BUSY (full throughput, one word per cycle).
REQ-018 BUSY + neither -> hold all registers.
REQ-019 FULL + downstream transfer -> OUT<=SKID, go to BUSY; up_valid is ignored while in FULL.
REQ-020 FULL without down_ready -> hold all registers; down_data stays stable while down_valid=1 and down_ready=0.
REQ-021 Latency: a word accepted at edge N appears on down_data with down_valid=1 after edge N when OUT was free; otherwise after the edge at which the word ahead of it leaves.
REQ-022 Ordering: words SHALL leave in acceptance order; no word is lost or duplicated.
REQ-023 up_ready SHALL be computed as a registered function of the next state (next state != FULL), so its value never depends combinationally on down_ready.
REQ-024 Payload is passed bit-exact; no arithmetic or width conversion.

Reset
REQ-025 While rst=1 at a rising edge: state<=EMPTY, OUT<=0, SKID<=0, down_valid<=0, up_ready<=0.
REQ-026 up_ready SHALL be 0 throughout reset, so no word is accepted during reset even if up_valid=1.
REQ-027 On the first rising edge with rst=0, up_ready SHALL become 1.
REQ-028 Reset asserted mid-operation SHALL discard any buffered words at the next edge and restore the REQ-025 values.

Verification
REQ-029 Reset: rst=1 for 2 cycles with up_valid=1 -> up_ready=0, down_valid=0, down_data=0; one edge after release, up_ready=1.
REQ-030 Single word: in EMPTY, up_valid=1, up_data=0x5A for one edge, down_ready=0 -> next cycle down_valid=1, down_data=0x5A, up_ready=1 (BUSY).
REQ-031 Skid fill: from BUSY with 0x5A, down_ready=0, push 0xC3 -> up_ready=0 (FULL), down_data remains 0x5A; raise down_ready -> 0x5A then 0xC3 delivered on consecutive cycles, up_ready returns to 1 after the first drain.
REQ-032 Streaming: down_ready=1 continuously, up_valid=1 with 0x01..0x08 -> one word per cycle out, 0x01..0x08 in order, up_ready never drops.
REQ-033 Toggling ready: down_ready alternates 0/1 every cycle, upstream offers random bytes whenever idle -> every accepted byte delivered exactly once in order; down_data stable during stalls.
REQ-034 Mid-stream reset: rst=1 while FULL -> next cycle down_valid=0, up_ready=0, both registers 0.
